// File: rtl/ftdi_fifo_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ftdi_bridge_pkg
// Purpose  : Shared types and default timing constants for the FTDI
//            asynchronous-FIFO bridge (state encoding, transfer direction).
// Contents : ftdi_state_e - bridge FSM states
//            ftdi_dir_e   - last transfer direction used by the arbiter
//            DEF_*        - default parameter values of ftdi_fifo_bridge
// Revision : 1.0 - initial release
// ============================================================================
package ftdi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_SETUP   = 3'd1,
    ST_WR_STROBE  = 3'd2,
    ST_WR_HOLD    = 3'd3,
    ST_RD_STROBE  = 3'd4,
    ST_RD_RECOVER = 3'd5
  } ftdi_state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } ftdi_dir_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_RXQ_DEPTH  = 1024;
  localparam int DEF_TXQ_DEPTH  = 1024;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_WR_PULSE   = 2;
  localparam int DEF_RD_PULSE   = 2;
  localparam int DEF_RD_RECOVER = 1;
  localparam int DEF_BURST      = 4;

  // Width of the shared state timer; comfortably covers any sane pulse width.
  localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/ftdi_fifo_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO. The head entry is
//            always visible on q while empty is low.
// Ports    : clock, reset_n (async, active low), clear (sync flush)
//            push/data   - write side, ignored when full
//            pop/q       - read side, ignored when empty
//            full, empty, level - occupancy status
// Params   : DATA_W - entry width, DEPTH - entries (power of two >= 4)
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        data,
  output logic [DATA_W-1:0]        q,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       level_q;
  logic              do_push;
  logic              do_pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign q     = mem_q[rd_ptr_q];

  // clear wins over any same-cycle push or pop
  assign do_push = push && !full  && !clear;
  assign do_pop  = pop  && !empty && !clear;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data;
  end

endmodule
`default_nettype wire

// File: rtl/ftdi_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_fifo_bridge
// Purpose  : Bridge between FTDI FT2232H/FT232H asynchronous-FIFO pins and
//            user valid/ready streams. Buffers both directions, synchronises
//            RXF#/TXE#, arbitrates read/write with bounded bursts and times
//            the RD#/WR# strobes in clock cycles.
// Ports    : clock, reset_n (async, active low), clear (sync flush)
//            rd_en, wr_en          - direction enables
//            tx_data/valid/ready   - user push into transmit queue
//            rx_data/valid/ready   - user pop from receive queue (FWFT)
//            rxq_level, txq_level  - queue occupancy
//            rxf_n, txe_n          - raw FTDI status pins
//            adbus_in/out/oe       - pad data bus (tristate in top level)
//            ftdi_rd_n, ftdi_wr_n  - FTDI strobes
//            busy                  - FSM not idle
// Config   : FTDI_BRIDGE_STATS_EN adds rx_count, tx_count (wrapping
//            transfer counters) and sticky rx_overflow_seen.
// Revision : 1.0 - initial release
// ============================================================================
module ftdi_fifo_bridge
  import ftdi_bridge_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RXQ_DEPTH  = DEF_RXQ_DEPTH,
  parameter int TXQ_DEPTH  = DEF_TXQ_DEPTH,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int WR_PULSE   = DEF_WR_PULSE,
  parameter int RD_PULSE   = DEF_RD_PULSE,
  parameter int RD_RECOVER = DEF_RD_RECOVER,
  parameter int BURST      = DEF_BURST
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         rd_en,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [DATA_W-1:0]            rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(RXQ_DEPTH):0]   rxq_level,
  output logic [$clog2(TXQ_DEPTH):0]   txq_level,
  input  logic                         rxf_n,
  input  logic                         txe_n,
  input  logic [DATA_W-1:0]            adbus_in,
  output logic [DATA_W-1:0]            adbus_out,
  output logic                         adbus_oe,
  output logic                         ftdi_rd_n,
  output logic                         ftdi_wr_n,
  output logic                         busy
`ifdef FTDI_BRIDGE_STATS_EN
  ,
  output logic [31:0]                  rx_count,
  output logic [31:0]                  tx_count,
  output logic                         rx_overflow_seen
`endif
);

  localparam int BW = $clog2(BURST + 1);

  // Status pin synchronisers (reset to the inactive level)
  logic rxf_meta_q, rxf_s_q;
  logic txe_meta_q, txe_s_q;

  // Holds tx_ready low until the first edge after reset release
  logic init_q;

  ftdi_state_e        state_q;
  logic [CNT_W-1:0]   cnt_q;
  ftdi_dir_e          last_dir_q, last_dir_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               rd_n_q, wr_n_q, oe_q;
  logic [DATA_W-1:0]  adbus_out_q;

  logic               tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_W-1:0]  tx_head;
  logic               tx_push, tx_pop, rx_push;
  logic               rd_elig, wr_elig, burst_done, pick_wr;
  logic               take_rd, take_wr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxf_meta_q <= 1'b1;
      rxf_s_q    <= 1'b1;
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
      init_q     <= 1'b0;
    end else begin
      rxf_meta_q <= rxf_n;
      rxf_s_q    <= rxf_meta_q;
      txe_meta_q <= txe_n;
      txe_s_q    <= txe_meta_q;
      init_q     <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Queues
  // --------------------------------------------------------------------------
  assign tx_ready = init_q && !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = !rx_empty;
  // Byte is captured at the end of the last RD# low cycle.
  assign rx_push  = (state_q == ST_RD_STROBE) && (cnt_q == '0);
  assign tx_pop   = take_wr;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TXQ_DEPTH)
  ) u_txq (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (tx_push),
    .pop     (tx_pop),
    .data    (tx_data),
    .q       (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (txq_level)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RXQ_DEPTH)
  ) u_rxq (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (rx_push),
    .pop     (rx_ready),
    .data    (adbus_in),
    .q       (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rxq_level)
  );

  // --------------------------------------------------------------------------
  // Arbitration (evaluated only in IDLE)
  // --------------------------------------------------------------------------
  always_comb begin
    rd_elig    = rd_en && !rxf_s_q && !rx_full;
    wr_elig    = wr_en && !txe_s_q && !tx_empty;
    burst_done = (burst_q >= BW'(BURST));
    // On a tie stay with the previous direction until its burst is spent.
    if (last_dir_q == DIR_WR) pick_wr = !burst_done;
    else                      pick_wr = burst_done;
    take_rd    = (state_q == ST_IDLE) && !clear && rd_elig && !(wr_elig && pick_wr);
    take_wr    = (state_q == ST_IDLE) && !clear && wr_elig && !take_rd;
    last_dir_d = last_dir_q;
    burst_d    = burst_q;
    if (take_rd || take_wr) begin
      last_dir_d = take_wr ? DIR_WR : DIR_RD;
      if (last_dir_d == last_dir_q) begin
        burst_d = burst_done ? burst_q : burst_q + BW'(1);
      end else begin
        burst_d = BW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Strobe FSM: cnt_q holds remaining cycles-1 of the current state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_dir_q  <= DIR_RD;
      burst_q     <= '0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      adbus_out_q <= '0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_dir_q  <= DIR_RD;
      burst_q     <= '0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      adbus_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          last_dir_q <= last_dir_d;
          burst_q    <= burst_d;
          if (take_rd) begin
            state_q <= ST_RD_STROBE;
            cnt_q   <= CNT_W'(RD_PULSE - 1);
            rd_n_q  <= 1'b0;
          end else if (take_wr) begin
            state_q     <= ST_WR_SETUP;
            cnt_q       <= CNT_W'(SETUP_CYC - 1);
            oe_q        <= 1'b1;
            adbus_out_q <= tx_head;
          end
        end
        ST_WR_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_WR_STROBE;
            cnt_q   <= CNT_W'(WR_PULSE - 1);
            wr_n_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WR_STROBE: begin
          if (cnt_q == '0) begin
            state_q <= ST_WR_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b0;
        end
        ST_RD_STROBE: begin
          if (cnt_q == '0) begin
            state_q <= ST_RD_RECOVER;
            cnt_q   <= CNT_W'(RD_RECOVER - 1);
            rd_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RD_RECOVER: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ftdi_rd_n = rd_n_q;
  assign ftdi_wr_n = wr_n_q;
  assign adbus_oe  = oe_q;
  assign adbus_out = adbus_out_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef FTDI_BRIDGE_STATS_EN
  logic [31:0] rx_count_q, tx_count_q;
  logic        ovf_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (clear) begin
        rx_count_q <= '0;
        tx_count_q <= '0;
      end else begin
        if (rx_push) rx_count_q <= rx_count_q + 32'd1;
        if (state_q == ST_WR_HOLD) tx_count_q <= tx_count_q + 32'd1;
      end
      // FTDI has data waiting but there is nowhere to put it.
      if (!rxf_s_q && rd_en && rx_full) ovf_q <= 1'b1;
    end
  end

  assign rx_count         = rx_count_q;
  assign tx_count         = tx_count_q;
  assign rx_overflow_seen = ovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/ftdi_fifo_bridge.md
# ftdi_fifo_bridge

Parametrised FTDI FT2232H/FT232H asynchronous-FIFO bridge: the second-generation host-link block between the FTDI chip pins and the LaserDrop packet logic. It buffers in both directions and drives the FTDI strobes with configurable pulse widths. The strobe widths are counted in `clock` cycles, so they can be retimed for faster clocks. It adds RXF#/TXE# synchronisers, valid/ready user handshakes, bounded-burst fair arbitration between read and write, and data sampling at the end of the RD# strobe.

## Interface
- `DATA_W`, 8: byte width on ADBUS and both queues.
- `RXQ_DEPTH`, 1024: receive queue depth, power of two ≥ 4.
- `TXQ_DEPTH`, 1024: transmit queue depth, power of two ≥ 4.
- `SETUP_CYC`, 1: cycles ADBUS is driven before WR# falls, ≥ 1.
- `WR_PULSE`, 2: WR# low cycles, ≥ 1.
- `RD_PULSE`, 2: RD# low cycles, ≥ 1.
- `RD_RECOVER`, 1: RD# high cycles after a read before re-arbitration, ≥ 1.
- `BURST`, 4: maximum consecutive same-direction transfers while the other direction is pending, ≥ 1.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush of both queues and the FSM.
- `rd_en` / `wr_en` in 1: enable FTDI→FPGA and FPGA→FTDI transfers.
- `tx_data` in DATA_W, `tx_valid` in 1, `tx_ready` out 1: user push into the transmit queue.
- `rx_data` out DATA_W, `rx_valid` out 1, `rx_ready` in 1: first-word-fall-through pop from the receive queue.
- `rxq_level` out $clog2(RXQ_DEPTH)+1, `txq_level` out $clog2(TXQ_DEPTH)+1: queue occupancy.
- `rxf_n` / `txe_n` in 1: raw FTDI status pins.
- `adbus_in` in DATA_W, `adbus_out` out DATA_W, `adbus_oe` out 1: pad bus (tristate lives in top level).
- `ftdi_rd_n` / `ftdi_wr_n` out 1: FTDI strobes.
- `busy` out 1: FSM not in IDLE.

## Operation
- `rxf_n` and `txe_n` each pass through a 2-flop synchroniser that resets to 1. Only the synchronised values (`rxf_s`, `txe_s`) are used.
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_RECOVER. A single down-counter times every state.
- Read is eligible when: `rd_en` && !`rxf_s` && rx queue has ≥ 1 free slot.
- Write is eligible when: `wr_en` && !`txe_s` && tx queue is non-empty.
- IDLE arbitration:
  - If only one direction is eligible, take it.
  - If both are eligible, continue the last direction until `BURST` consecutive transfers, then switch. The burst count resets when the opposite direction is taken.
  - After reset, read wins a tie.
- Write sequence:
  - IDLE→WR_SETUP pops the tx queue and registers the byte into `adbus_out`.
  - WR_SETUP lasts `SETUP_CYC` cycles with `adbus_oe`=1.
  - WR_STROBE lasts `WR_PULSE` cycles with `ftdi_wr_n`=0 and `adbus_oe`=1.
  - WR_HOLD lasts 1 cycle with `adbus_oe`=1 and WR# high, then returns to IDLE.
  - `adbus_out` is stable from WR_SETUP through WR_HOLD.
- Read sequence:
  - RD_STROBE lasts `RD_PULSE` cycles with `ftdi_rd_n`=0.
  - `adbus_in` is sampled and pushed into the rx queue on the last RD_STROBE cycle.
  - RD_RECOVER lasts `RD_RECOVER` cycles, then returns to IDLE.
- `adbus_oe`=0 in every state outside the write sequence.
- User side:
  - `tx_ready` = !tx_full. A push happens on `tx_valid`&&`tx_ready`.
  - `rx_valid` = !rx_empty. A pop happens on `rx_valid`&&`rx_ready`.
  - A simultaneous user pop and FSM push on the rx queue is legal; the level is unchanged.
- `clear` is synchronous:
  - FSM goes to IDLE and both queues empty on the next edge.
  - Strobes and `adbus_oe` are deasserted from that edge.
  - An in-flight byte is dropped and the burst counter resets.
  - `clear` has priority over all same-cycle pushes and pops.
- Disabling `rd_en` or `wr_en` mid-sequence does not abort the sequence; it affects only the next arbitration.
- Reset values: `ftdi_rd_n`=1, `ftdi_wr_n`=1, `adbus_oe`=0, `adbus_out`=0, `rx_valid`=0, `tx_ready`=0 while `reset_n`=0, both levels 0, `busy`=0, FSM in IDLE.
- Asserting `reset_n` low mid-strobe releases the strobe immediately (asynchronously).

## Timing
- `rxf_n` falling to `ftdi_rd_n` low: 3 edges (2 synchroniser, 1 IDLE decision).
- Read cycle length: `RD_PULSE`+`RD_RECOVER`+1 cycles. With defaults, 4.
- Byte pushed on the last strobe edge appears on `rx_data`/`rx_valid` one cycle later.
- Write cycle length: `SETUP_CYC`+`WR_PULSE`+2 cycles. With defaults, 5.
- The FSM never re-enters a strobe without passing through IDLE. RXF#/TXE# are re-checked each transfer.

## Configuration
- `FTDI_BRIDGE_STATS_EN`: when defined, adds outputs `rx_count` and `tx_count` (32 bits each) and `rx_overflow_seen` (1 bit).
  - `rx_count` and `tx_count` are wrapping counters of completed FTDI transfers. They are zeroed by reset and by `clear`.
  - `rx_overflow_seen` is sticky. It sets when a read is pending (!`rxf_s`&&`rd_en`) while the rx queue is full.
- When not defined, these ports and their logic do not exist.

## Structure
- Package `ftdi_bridge_pkg`:
  - state enum `ftdi_state_e`;
  - direction enum `ftdi_dir_e`;
  - localparam default timing constants.
- Sub-module `sync_fifo`, instantiated twice, parameters DATA_W and DEPTH:
  - ports: `clock`, `reset_n`, `clear`, push, pop, data, q, full, empty, level;
  - first-word-fall-through;
  - replaces the vendor FIFO IP.

## Test plan
- Single write: push 0xA5, `txe_n`=0, `wr_en`=1. Expect:
  - `adbus_oe` high for 4 cycles;
  - `ftdi_wr_n` low for exactly 2 cycles;
  - `adbus_out`=0xA5 throughout.
- Read burst: `rxf_n`=0, bus sequence 0x01..0x08, `rx_ready`=1. Expect:
  - 8 bytes popped in order;
  - `ftdi_rd_n` low 2 cycles per byte;
  - each byte sampled on the last strobe cycle.
- Fair arbitration: `BURST`=4, both directions continuously eligible. Expect the strobe pattern 4 reads, 4 writes, repeating.
- Rx full: `RXQ_DEPTH`=4, `rx_ready`=0, `rxf_n`=0. Expect:
  - exactly 4 reads, then `ftdi_rd_n` held high;
  - one pop restarts reading within 2 cycles;
  - with stats: `rx_overflow_seen`=1.
- `clear` on the 2nd WR_STROBE cycle with 3 bytes queued. Expect:
  - `ftdi_wr_n`=1 and `adbus_oe`=0 on the next edge;
  - `txq_level`=0;
  - no further writes.
- `reset_n` low during RD_STROBE. Expect `ftdi_rd_n`=1 with no clock edge; all outputs at reset values.
